// File: rtl/vrf_read_arbiter.sv
// Round-robin arbiter sharing the VRF read ports among the v_lane requesters, with per-port read-latency tracking.
// Optional build macro VRF_RD_ARB_PRIO0_EN: requester 0 gets strict priority on port 0.
module vrf_read_arbiter #(
  parameter int REQ_NUM      = 8,
  parameter int R_PORTS_NUM  = 4,
  parameter int MEM_DEPTH    = 512,
  parameter int MEM_WIDTH    = 32,
  parameter int READ_LATENCY = 2,
  localparam int ADDR_W      = $clog2(MEM_DEPTH),
  localparam int ID_W        = $clog2(REQ_NUM)
) (
  input  logic                             clk,
  input  logic                             rstn,
  input  logic [REQ_NUM-1:0]               req_valid_i,
  input  logic [REQ_NUM*ADDR_W-1:0]        req_addr_i,
  output logic [REQ_NUM-1:0]               req_ready_o,
  output logic [R_PORTS_NUM*ADDR_W-1:0]    raddr_o,
  output logic [R_PORTS_NUM-1:0]           ren_o,
  output logic [R_PORTS_NUM-1:0]           oreg_en_o,
  input  logic [R_PORTS_NUM*MEM_WIDTH-1:0] dout_i,
  output logic [REQ_NUM-1:0]               rsp_valid_o,
  output logic [REQ_NUM*MEM_WIDTH-1:0]     rsp_data_o,
  output logic                             busy_o
);

  logic [ID_W-1:0]         rr_ptr;
  logic [ID_W-1:0]         nxt_ptr;
  logic [ID_W-1:0]         port_id [R_PORTS_NUM];
  logic [READ_LATENCY-1:0] pipe_v  [R_PORTS_NUM];
  logic [ID_W-1:0]         pipe_id [R_PORTS_NUM][READ_LATENCY];

  // Scan from rr_ptr; the n-th valid requester found lands on port n.
  always_comb begin
    int              cnt;
    logic [ID_W-1:0] idx;
    logic            skip;
    cnt         = 0;
    idx         = '0;
    skip        = 1'b0;
    nxt_ptr     = rr_ptr;
    req_ready_o = '0;
    ren_o       = '0;
    raddr_o     = '0;
    for (int p = 0; p < R_PORTS_NUM; p++) port_id[p] = '0;
`ifdef VRF_RD_ARB_PRIO0_EN
    if (req_valid_i[0]) begin
      req_ready_o[0]       = 1'b1;
      ren_o[0]             = 1'b1;
      raddr_o[ADDR_W-1:0]  = req_addr_i[ADDR_W-1:0];
      cnt                  = 1;
    end
`endif
    for (int k = 0; k < REQ_NUM; k++) begin
      idx = rr_ptr + ID_W'(k);
`ifdef VRF_RD_ARB_PRIO0_EN
      skip = (idx == '0);
`endif
      if (req_valid_i[idx] && !skip && cnt < R_PORTS_NUM) begin
        req_ready_o[idx] = 1'b1;
        for (int p = 0; p < R_PORTS_NUM; p++) begin
          if (p == cnt) begin
            ren_o[p]                     = 1'b1;
            raddr_o[p*ADDR_W +: ADDR_W]  = req_addr_i[idx*ADDR_W +: ADDR_W];
            port_id[p]                   = idx;
          end
        end
        nxt_ptr = idx + 1'b1;
        cnt     = cnt + 1;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rr_ptr <= '0;
      for (int p = 0; p < R_PORTS_NUM; p++) begin
        pipe_v[p] <= '0;
        for (int s = 0; s < READ_LATENCY; s++) pipe_id[p][s] <= '0;
      end
    end else begin
      rr_ptr <= nxt_ptr;
      for (int p = 0; p < R_PORTS_NUM; p++) begin
        pipe_v[p][0]  <= ren_o[p];
        pipe_id[p][0] <= port_id[p];
        for (int s = 1; s < READ_LATENCY; s++) begin
          pipe_v[p][s]  <= pipe_v[p][s-1];
          pipe_id[p][s] <= pipe_id[p][s-1];
        end
      end
    end
  end

  // A BRAM without output register has nothing to enable, so hold it on.
  generate
    if (READ_LATENCY >= 2) begin : g_oreg
      for (genvar p = 0; p < R_PORTS_NUM; p++) begin : g_port
        assign oreg_en_o[p] = pipe_v[p][READ_LATENCY-2];
      end
    end else begin : g_oreg_const
      assign oreg_en_o = '1;
    end
  endgenerate

  always_comb begin
    busy_o = 1'b0;
    for (int p = 0; p < R_PORTS_NUM; p++) busy_o = busy_o | (|pipe_v[p]);
  end

  always_comb begin
    rsp_valid_o = '0;
    rsp_data_o  = '0;
    for (int p = 0; p < R_PORTS_NUM; p++) begin
      if (pipe_v[p][READ_LATENCY-1]) begin
        rsp_valid_o[pipe_id[p][READ_LATENCY-1]] = 1'b1;
        rsp_data_o[pipe_id[p][READ_LATENCY-1]*MEM_WIDTH +: MEM_WIDTH] =
          dout_i[p*MEM_WIDTH +: MEM_WIDTH];
      end
    end
  end

endmodule

// File: tb/tb_vrf_read_arbiter.sv
// Directed self-checking bench for vrf_read_arbiter (default parameters).
module tb_vrf_read_arbiter;
  localparam int RN = 8, PN = 4, AW = 9, DW = 32;

  logic             clk = 1'b0;
  logic             rstn = 1'b0;
  logic [RN-1:0]    req_valid_i = '0;
  logic [RN*AW-1:0] req_addr_i = '0;
  logic [RN-1:0]    req_ready_o;
  logic [PN*AW-1:0] raddr_o;
  logic [PN-1:0]    ren_o;
  logic [PN-1:0]    oreg_en_o;
  logic [PN*DW-1:0] dout_i = '0;
  logic [RN-1:0]    rsp_valid_o;
  logic [RN*DW-1:0] rsp_data_o;
  logic             busy_o;

  int n_cmp = 0;
  int n_err = 0;

  vrf_read_arbiter dut (
    .clk(clk), .rstn(rstn), .req_valid_i(req_valid_i), .req_addr_i(req_addr_i),
    .req_ready_o(req_ready_o), .raddr_o(raddr_o), .ren_o(ren_o), .oreg_en_o(oreg_en_o),
    .dout_i(dout_i), .rsp_valid_o(rsp_valid_o), .rsp_data_o(rsp_data_o), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, n_cmp=%0d", n_cmp);
    $fatal(1);
  end

  function automatic logic [AW-1:0] raddr(input int p);
    return raddr_o[p*AW +: AW];
  endfunction

  function automatic logic [DW-1:0] rdata(input int r);
    return rsp_data_o[r*DW +: DW];
  endfunction

  function automatic logic [AW-1:0] addr_of(input int r);
    return AW'(9'h100 + r * 3);
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    req_valid_i = '0;
    rstn = 1'b0;
    cyc();
    cyc();
    rstn = 1'b1;
  endtask

  task automatic set_all_addrs();
    for (int r = 0; r < RN; r++) req_addr_i[r*AW +: AW] = addr_of(r);
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    req_valid_i = '0;
    dout_i = {PN{32'hDEAD_BEEF}};
    cyc();
    #2;
    n_cmp++; if (rsp_valid_o !== '0) begin n_err++; $display("FAIL reset_rsp_valid got=%h exp=0", rsp_valid_o); end
    n_cmp++; if (rsp_data_o !== '0) begin n_err++; $display("FAIL reset_rsp_data got=%h exp=0", rsp_data_o); end
    n_cmp++; if (oreg_en_o !== '0) begin n_err++; $display("FAIL reset_oreg_en got=%h exp=0", oreg_en_o); end
    n_cmp++; if (busy_o !== 1'b0) begin n_err++; $display("FAIL reset_busy got=%b exp=0", busy_o); end
    n_cmp++; if (ren_o !== '0 || raddr_o !== '0 || req_ready_o !== '0) begin n_err++; $display("FAIL reset_idle_ports ren=%h raddr=%h ready=%h exp=0", ren_o, raddr_o, req_ready_o); end
    cyc();
    rstn = 1'b1;
    dout_i = '0;
  endtask

  task automatic test_single();
    apply_reset();
    cyc();
    req_valid_i = 8'h01;
    req_addr_i[AW-1:0] = 9'd5;
    #2;
    n_cmp++; if (req_ready_o !== 8'h01) begin n_err++; $display("FAIL single_ready got=%h exp=01", req_ready_o); end
    n_cmp++; if (ren_o !== 4'b0001) begin n_err++; $display("FAIL single_ren got=%b exp=0001", ren_o); end
    n_cmp++; if (raddr(0) !== 9'd5) begin n_err++; $display("FAIL single_raddr got=%0d exp=5", raddr(0)); end
    cyc();
    req_valid_i = '0;
    #2;
    n_cmp++; if (oreg_en_o !== 4'b0001) begin n_err++; $display("FAIL single_oreg got=%b exp=0001", oreg_en_o); end
    n_cmp++; if (busy_o !== 1'b1) begin n_err++; $display("FAIL single_busy got=%b exp=1", busy_o); end
    n_cmp++; if (rsp_valid_o !== '0) begin n_err++; $display("FAIL single_rsp_early got=%h exp=0", rsp_valid_o); end
    cyc();
    dout_i[DW-1:0] = 32'hA5A5_0001;
    #2;
    n_cmp++; if (rsp_valid_o !== 8'h01) begin n_err++; $display("FAIL single_rsp_valid got=%h exp=01", rsp_valid_o); end
    n_cmp++; if (rsp_data_o !== (RN*DW)'(32'hA5A5_0001)) begin n_err++; $display("FAIL single_rsp_data got=%h exp=a5a50001 in word 0 only", rsp_data_o); end
    n_cmp++; if (oreg_en_o !== 4'b0000) begin n_err++; $display("FAIL single_oreg_off got=%b exp=0000", oreg_en_o); end
    cyc();
    #2;
    n_cmp++; if (rsp_valid_o !== '0 || busy_o !== 1'b0) begin n_err++; $display("FAIL single_drain rsp=%h busy=%b exp=0/0", rsp_valid_o, busy_o); end
    dout_i = '0;
  endtask

  task automatic test_all_valid();
    logic [RN-1:0] exp_rdy;
    int base;
    apply_reset();
    set_all_addrs();
    for (int c = 0; c < 4; c++) begin
      cyc();
      req_valid_i = 8'hFF;
      for (int p = 0; p < PN; p++) dout_i[p*DW +: DW] = 32'hC000_0000 + 32'(c * 16 + p);
      #2;
      exp_rdy = (c % 2 == 0) ? 8'h0F : 8'hF0;
      base = (c % 2 == 0) ? 0 : 4;
      n_cmp++; if (req_ready_o !== exp_rdy) begin n_err++; $display("FAIL all_ready c%0d got=%h exp=%h", c, req_ready_o, exp_rdy); end
      for (int p = 0; p < PN; p++) begin
        n_cmp++; if (raddr(p) !== addr_of(base + p)) begin n_err++; $display("FAIL all_raddr c%0d p%0d got=%h exp=%h", c, p, raddr(p), addr_of(base + p)); end
      end
      if (c >= 2) begin
        n_cmp++; if (rsp_valid_o !== exp_rdy) begin n_err++; $display("FAIL all_rsp_valid c%0d got=%h exp=%h", c, rsp_valid_o, exp_rdy); end
        for (int p = 0; p < PN; p++) begin
          n_cmp++; if (rdata(base + p) !== 32'hC000_0000 + 32'(c * 16 + p)) begin n_err++; $display("FAIL all_rsp_data c%0d r%0d got=%h exp=%h", c, base + p, rdata(base + p), 32'hC000_0000 + 32'(c * 16 + p)); end
        end
      end
    end
    cyc();
    req_valid_i = '0;
    cyc();
    cyc();
    #2;
    n_cmp++; if (busy_o !== 1'b0) begin n_err++; $display("FAIL all_drain_busy got=%b exp=0", busy_o); end
    dout_i = '0;
  endtask

  task automatic test_wrap_stall();
    apply_reset();
    set_all_addrs();
    cyc();
    req_valid_i = 8'h20;
    #2;
    n_cmp++; if (req_ready_o !== 8'h20) begin n_err++; $display("FAIL wrap_pre got=%h exp=20", req_ready_o); end
    cyc();
    req_valid_i = 8'hC7;
    #2;
    n_cmp++; if (req_ready_o !== 8'hC3) begin n_err++; $display("FAIL wrap_ready got=%h exp=c3", req_ready_o); end
    n_cmp++; if (raddr(0) !== addr_of(6) || raddr(1) !== addr_of(7) || raddr(2) !== addr_of(0) || raddr(3) !== addr_of(1)) begin n_err++; $display("FAIL wrap_order got=%h exp=%h %h %h %h", raddr_o, addr_of(6), addr_of(7), addr_of(0), addr_of(1)); end
    cyc();
    req_valid_i = 8'h04;
    #2;
    n_cmp++; if (req_ready_o !== 8'h04 || ren_o !== 4'b0001 || raddr(0) !== addr_of(2)) begin n_err++; $display("FAIL wrap_stalled ready=%h ren=%b raddr0=%h exp=04 0001 %h", req_ready_o, ren_o, raddr(0), addr_of(2)); end
    cyc();
    req_valid_i = '0;
  endtask

  task automatic test_back_to_back();
    apply_reset();
    cyc();
    req_valid_i = 8'h08;
    req_addr_i[3*AW +: AW] = 9'h033;
    #2;
    n_cmp++; if (req_ready_o !== 8'h08) begin n_err++; $display("FAIL b2b_ready1 got=%h exp=08", req_ready_o); end
    cyc();
    req_valid_i = '0;
    cyc();
    req_valid_i = 8'h08;
    req_addr_i[3*AW +: AW] = 9'h034;
    dout_i[DW-1:0] = 32'h1111_1111;
    #2;
    n_cmp++; if (rsp_valid_o !== 8'h08 || rdata(3) !== 32'h1111_1111) begin n_err++; $display("FAIL b2b_rsp1 valid=%h data=%h exp=08 11111111", rsp_valid_o, rdata(3)); end
    n_cmp++; if (req_ready_o !== 8'h08 || raddr(0) !== 9'h034) begin n_err++; $display("FAIL b2b_grant2 ready=%h raddr0=%h exp=08 034", req_ready_o, raddr(0)); end
    cyc();
    req_valid_i = '0;
    dout_i[DW-1:0] = 32'h5555_5555;
    #2;
    n_cmp++; if (rsp_valid_o !== '0) begin n_err++; $display("FAIL b2b_gap got=%h exp=0", rsp_valid_o); end
    cyc();
    dout_i[DW-1:0] = 32'h2222_2222;
    #2;
    n_cmp++; if (rsp_valid_o !== 8'h08 || rdata(3) !== 32'h2222_2222) begin n_err++; $display("FAIL b2b_rsp2 valid=%h data=%h exp=08 22222222", rsp_valid_o, rdata(3)); end
    dout_i = '0;
  endtask

  task automatic test_reset_midflight();
    apply_reset();
    dout_i = {PN{32'h7777_7777}};
    cyc();
    req_valid_i = 8'h04;
    req_addr_i[2*AW +: AW] = 9'h077;
    #2;
    n_cmp++; if (req_ready_o !== 8'h04) begin n_err++; $display("FAIL rmid_grant got=%h exp=04", req_ready_o); end
    cyc();
    req_valid_i = '0;
    #2;
    n_cmp++; if (oreg_en_o !== 4'b0001 || busy_o !== 1'b1) begin n_err++; $display("FAIL rmid_inflight oreg=%b busy=%b exp=0001 1", oreg_en_o, busy_o); end
    rstn = 1'b0;
    #1;
    n_cmp++; if (oreg_en_o !== '0 || busy_o !== 1'b0 || rsp_valid_o !== '0) begin n_err++; $display("FAIL rmid_drop oreg=%b busy=%b rsp=%h exp=0", oreg_en_o, busy_o, rsp_valid_o); end
    cyc();
    rstn = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #2;
      n_cmp++; if (rsp_valid_o !== '0 || rsp_data_o !== '0) begin n_err++; $display("FAIL rmid_after c%0d rsp=%h data=%h exp=0", c, rsp_valid_o, rsp_data_o); end
      cyc();
    end
    dout_i = '0;
  endtask

`ifdef VRF_RD_ARB_PRIO0_EN
  task automatic test_prio0();
    logic [RN-1:0] exp_rdy [3];
    int            exp_req [3][PN];
    exp_rdy = '{8'h0F, 8'h71, 8'h87};
    exp_req = '{'{0, 1, 2, 3}, '{0, 4, 5, 6}, '{0, 7, 1, 2}};
    apply_reset();
    set_all_addrs();
    for (int c = 0; c < 3; c++) begin
      cyc();
      req_valid_i = 8'hFF;
      #2;
      n_cmp++; if (req_ready_o !== exp_rdy[c]) begin n_err++; $display("FAIL prio_ready c%0d got=%h exp=%h", c, req_ready_o, exp_rdy[c]); end
      for (int p = 0; p < PN; p++) begin
        n_cmp++; if (raddr(p) !== addr_of(exp_req[c][p])) begin n_err++; $display("FAIL prio_raddr c%0d p%0d got=%h exp=%h", c, p, raddr(p), addr_of(exp_req[c][p])); end
      end
    end
    cyc();
    req_valid_i = '0;
  endtask
`endif

  initial begin
    test_reset();
    test_single();
`ifndef VRF_RD_ARB_PRIO0_EN
    test_all_valid();
    test_wrap_stall();
`else
    test_prio0();
`endif
    test_back_to_back();
    test_reset_midflight();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
